// File: rtl/toggle_mon_pkg.sv
// Shared encodings and default sizing for the toggle-stream monitors.
package toggle_mon_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_STUCK = 3'd4;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_EDGE_W  = 16;

endpackage

// File: rtl/toggle_edge_detect.sv
// One-cycle rise/fall pulses for a stream already synchronous to clk.
module toggle_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;

    // din_q follows din regardless of the monitor's state so edges are never stale.
    always_ff @(posedge clk) begin
        if (reset)
            din_q <= 1'b0;
        else
            din_q <= din;
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/toggle_monitor.sv
// Measures high/low phase lengths of a toggle stream, counts edges and flags a stuck source.
module toggle_monitor
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int EDGE_W  = DEF_EDGE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              en,
    input  logic              clr,
    output logic [CNT_W-1:0]  high_len,
    output logic [CNT_W-1:0]  low_len,
    output logic              meas_valid,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic             rise;
    logic             fall;
    logic [2:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] hi_len_r;

    toggle_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .rise  (rise),
        .fall  (fall)
    );

    // Priority: reset, clr, STUCK hold, en low, then normal measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            hi_len_r   <= '0;
            high_len   <= '0;
            low_len    <= '0;
            meas_valid <= 1'b0;
            edge_cnt   <= '0;
            stuck      <= 1'b0;
        end else if (clr) begin
            stuck      <= 1'b0;
            edge_cnt   <= '0;
            run_cnt    <= '0;
            meas_valid <= 1'b0;
            state      <= en ? ST_SYNC : ST_IDLE;
        end else if (state == ST_STUCK) begin
            meas_valid <= 1'b0;
            stuck      <= 1'b1;
        end else if (!en) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if ((rise | fall) && (state != ST_IDLE))
                edge_cnt <= edge_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    run_cnt <= '0;
                    state   <= ST_SYNC;
                end
                // Falls are ignored until the first rise aligns us to a period start.
                ST_SYNC: begin
                    if (rise) begin
                        run_cnt <= CNT_W'(1);
                        state   <= ST_HIGH;
                    end else if (run_cnt == TIMEOUT_V) begin
                        state <= ST_STUCK;
                        stuck <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_len_r <= run_cnt;
                        run_cnt  <= CNT_W'(1);
                        state    <= ST_LOW;
                    end else if (run_cnt == TIMEOUT_V) begin
                        state <= ST_STUCK;
                        stuck <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_len   <= hi_len_r;
                        low_len    <= run_cnt;
                        meas_valid <= 1'b1;
                        run_cnt    <= CNT_W'(1);
                        state      <= ST_HIGH;
                    end else if (run_cnt == TIMEOUT_V) begin
                        state <= ST_STUCK;
                        stuck <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                default: begin
                    run_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor: period measurement, timeout, clr, en, reset and edge wrap.
module tb_toggle_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;

    logic [7:0]  high_len;
    logic [7:0]  low_len;
    logic        meas_valid;
    logic [15:0] edge_cnt;
    logic        stuck;

    logic [7:0]  high_len4;
    logic [7:0]  low_len4;
    logic        meas_valid4;
    logic [3:0]  edge_cnt4;
    logic        stuck4;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;

    always #5 clk = ~clk;

    toggle_monitor #(.CNT_W(8), .TIMEOUT(16), .EDGE_W(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .clr        (clr),
        .high_len   (high_len),
        .low_len    (low_len),
        .meas_valid (meas_valid),
        .edge_cnt   (edge_cnt),
        .stuck      (stuck)
    );

    toggle_monitor #(.CNT_W(8), .TIMEOUT(16), .EDGE_W(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .clr        (clr),
        .high_len   (high_len4),
        .low_len    (low_len4),
        .meas_valid (meas_valid4),
        .edge_cnt   (edge_cnt4),
        .stuck      (stuck4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply din, clock once, then look at outputs just after the edge.
    task automatic tick(input logic d);
        din = d;
        @(posedge clk);
        #1;
        if (meas_valid) n_strobe++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_high_len", 32'(high_len), 0);
        check("rst_low_len", 32'(low_len), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_edge_cnt", 32'(edge_cnt), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_edge_cnt4", 32'(edge_cnt4), 0);

        // Period-2 reference source
        en = 1'b1;
        n_strobe = 0;
        tick(1'b0);
        tick(1'b1);
        check("p2_first_rise_edge", 32'(edge_cnt), 1);
        tick(1'b0);
        check("p2_no_strobe_yet", 32'(n_strobe), 0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            check("p2_strobe", 32'(meas_valid), 1);
            check("p2_high_len", 32'(high_len), 1);
            check("p2_low_len", 32'(low_len), 1);
            check("p2_edge_rise", 32'(edge_cnt), 32'(3 + 2 * i));
            tick(1'b0);
            check("p2_strobe_off", 32'(meas_valid), 0);
            check("p2_edge_fall", 32'(edge_cnt), 32'(4 + 2 * i));
        end

        // 3 high / 5 low
        do_reset();
        en = 1'b1;
        tick(1'b0);
        n_strobe = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                tick(1'b1);
                if (k == 0 && p > 0) begin
                    check("p35_strobe", 32'(meas_valid), 1);
                    check("p35_high_len", 32'(high_len), 3);
                    check("p35_low_len", 32'(low_len), 5);
                end
            end
            for (int k = 0; k < 5; k++) tick(1'b0);
        end
        check("p35_strobe_count", 32'(n_strobe), 3);
        check("p35_edge_cnt", 32'(edge_cnt), 8);

        // Stuck high after a rise, then clr
        do_reset();
        en = 1'b1;
        tick(1'b0);
        n_strobe = 0;
        tick(1'b1);
        repeat (15) tick(1'b1);
        check("to_at_limit_not_stuck", 32'(stuck), 0);
        tick(1'b1);
        check("to_stuck_set", 32'(stuck), 1);
        repeat (3) tick(1'b1);
        check("to_no_strobe", 32'(n_strobe), 0);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        check("to_stuck_sticky", 32'(stuck), 1);
        check("to_edge_frozen", 32'(edge_cnt), 1);
        clr = 1'b1;
        tick(1'b1);
        clr = 1'b0;
        check("clr_stuck", 32'(stuck), 0);
        check("clr_edge_cnt", 32'(edge_cnt), 0);
        tick(1'b0);
        check("clr_sync_fall_counted", 32'(edge_cnt), 1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("clr_resume_strobe", 32'(meas_valid), 1);
        check("clr_resume_high", 32'(high_len), 3);
        check("clr_resume_low", 32'(low_len), 4);
        check("clr_resume_edge", 32'(edge_cnt), 4);
        check("clr_resume_strobes", 32'(n_strobe), 1);

        // en dropped mid-HIGH
        n_strobe = 0;
        tick(1'b1);
        en = 1'b0;
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        check("en_off_edge_hold", 32'(edge_cnt), 4);
        check("en_off_high_hold", 32'(high_len), 3);
        check("en_off_low_hold", 32'(low_len), 4);
        en = 1'b1;
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("en_no_strobe", 32'(n_strobe), 0);
        check("en_high_still_old", 32'(high_len), 3);
        tick(1'b1);
        check("en_next_strobe", 32'(meas_valid), 1);
        check("en_next_high", 32'(high_len), 2);
        check("en_next_low", 32'(low_len), 2);
        check("en_next_edge", 32'(edge_cnt), 8);

        // Reset mid-LOW coinciding with a rise
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1;
        tick(1'b1);
        check("midrst_meas_valid", 32'(meas_valid), 0);
        check("midrst_high_len", 32'(high_len), 0);
        check("midrst_low_len", 32'(low_len), 0);
        check("midrst_edge_cnt", 32'(edge_cnt), 0);
        check("midrst_stuck", 32'(stuck), 0);
        reset = 1'b0;
        tick(1'b1);
        check("midrst_no_late_strobe", 32'(meas_valid), 0);

        // clr coinciding with a SYNC timeout, then a real SYNC timeout
        do_reset();
        en = 1'b1;
        tick(1'b0);
        repeat (16) tick(1'b0);
        check("sync_at_limit_not_stuck", 32'(stuck), 0);
        clr = 1'b1;
        tick(1'b0);
        clr = 1'b0;
        check("clr_beats_timeout", 32'(stuck), 0);
        tick(1'b0);
        check("clr_timeout_after", 32'(stuck), 0);
        repeat (15) tick(1'b0);
        check("sync_limit_again", 32'(stuck), 0);
        tick(1'b0);
        check("sync_timeout_stuck", 32'(stuck), 1);

        // Edge counter wrap on the 4-bit instance
        do_reset();
        en = 1'b1;
        tick(1'b0);
        for (int i = 1; i <= 17; i++) begin
            tick(logic'(i % 2));
            if (i == 16) begin
                check("wrap16_edge4", 32'(edge_cnt4), 0);
                check("wrap16_edge16", 32'(edge_cnt), 16);
            end
        end
        check("wrap17_edge4", 32'(edge_cnt4), 1);
        check("wrap17_edge16", 32'(edge_cnt), 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
